mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles allowed without mem_ack before the access is abandoned.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports are:
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ex_valid  in  1  EX/MEM holds a valid instruction; inputs stable while stall=1.
REQ-006 aluout_in  in  32  ALU result / memory address; writedata_in  in  32  store data.
REQ-007 memread_in, memwrite_in, regwrite_in, memtoreg_in  in  1 each  control from EX/MEM.
REQ-008 write_reg_in  in  5  destination register.
REQ-009 mem_req, mem_we  out  1 each  data-memory request and write enable; mem_addr, mem_wdata  out  32 each.
REQ-010 mem_ack  in  1  memory completion; mem_rdata  in  32  load data, valid with mem_ack.
REQ-011 stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-012 wb_valid  out  1  MEM/WB inputs are meaningful this cycle.
REQ-013 readdata_out, ULAout_out  out  32 each; write_reg_out  out  5; regwrite_out, memtoreg_out  out  1 each: drive MEM/WB inputs.
REQ-014 busy  out  1  state==ACCESS; err_access, err_timeout  out  1 each, sticky.
REQ-015 load_count, store_count, stall_count  out  32 each  performance counters.

Function
REQ-016 The block SHALL implement two states, IDLE=0 and ACCESS=1, plus a wait counter of width clog2(TIMEOUT_CYCLES+1).
REQ-017 IDLE, ex_valid=1, memread_in=memwrite_in=0: wb_valid=1 in the same cycle, with stall=0 and combinational pass-through (regwrite_out=regwrite_in).
REQ-018 IDLE, ex_valid=1, exactly one of memread_in/memwrite_in, aluout_in[1:0]=00: stall=1 and wb_valid=0; next state ACCESS; mem_addr/mem_we/mem_wdata registered from inputs; wait counter cleared.
REQ-019 ACCESS: mem_req=1 with address/we/wdata held constant; stall=1 while mem_ack=0; wait counter increments each cycle.
REQ-020 ACCESS with mem_ack=1: wb_valid=1, stall=0, readdata_out=mem_rdata (loads), next state IDLE, mem_req=0 next cycle; minimum load/store latency is 2 cycles (1 stall cycle).
REQ-021 ACCESS, wait counter==TIMEOUT_CYCLES-1, mem_ack=0: wb_valid=1, regwrite_out=0, stall=0, err_timeout set, next state IDLE.
REQ-022 Illegal access (both memread_in and memwrite_in set, or misaligned address with either set): no request, wb_valid=1, regwrite_out=0, stall=0, err_access set.
REQ-023 mem_ack in IDLE SHALL be ignored; ex_valid=0 in IDLE SHALL give wb_valid=0.
REQ-024 wb_valid=0 SHALL force regwrite_out=0; ULAout_out=aluout_in, write_reg_out=write_reg_in, memtoreg_out=memtoreg_in always.
REQ-025 Outside a completing load, readdata_out SHALL be 0.
REQ-026 Counters (modulo 2^32): load_count +1 on load ack; store_count +1 on store ack; stall_count +1 per cycle with stall=1.

Reset
REQ-027 Reset SHALL force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wait counter=0, err_access=0, err_timeout=0, and all counters=0, asynchronously, including mid-ACCESS.
REQ-028 During and after reset with ex_valid=0, stall, wb_valid, regwrite_out, and busy SHALL be 0.

Configuration
REQ-029 Macro MEM_STATS_EN defined: load_count, store_count, stall_count implemented per REQ-026.
REQ-030 MEM_STATS_EN undefined: the three counters are tied to 32'h0, no counter flops are synthesized, and all other behaviour is identical.

Verification
REQ-031 ALU op, aluout_in=0x1234, regwrite_in=1, write_reg_in=5 -> same cycle wb_valid=1, regwrite_out=1, ULAout_out=0x1234, stall=0.
REQ-032 Load at 0x40 with ack after 3 ACCESS cycles, mem_rdata=0xDEADBEEF -> stall high 4 cycles, wb_valid on ack cycle, readdata_out=0xDEADBEEF, load_count=1, stall_count=4.
REQ-033 Store at 0x44 with data 0xCAFE0001 and ack in 1st ACCESS cycle -> mem_we=1, mem_wdata=0xCAFE0001, store_count=1, regwrite_out=0.
REQ-034 Load at 0x42 -> no mem_req, wb_valid=1, regwrite_out=0, err_access=1, counters unchanged.
REQ-035 Load with TIMEOUT_CYCLES=16 and no ack -> 16 ACCESS cycles, then err_timeout=1, regwrite_out=0, state IDLE, mem_req=0 next cycle.
REQ-036 Reset asserted in 2nd ACCESS cycle -> mem_req=0 and stall=0 immediately, all counters 0, and a late mem_ack has no effect.

Source files
------------

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Data-memory request/response bus between the MEM stage and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Pipeline MEM stage; stalls the pipe around data-memory accesses,
//            with access/timeout error flags. Define MEM_STATS_EN to build the
//            load/store/stall performance counters (tied to zero otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        ex_valid,
    input  wire logic [31:0] aluout_in,
    input  wire logic [31:0] writedata_in,
    input  wire logic        memread_in,
    input  wire logic        memwrite_in,
    input  wire logic        regwrite_in,
    input  wire logic        memtoreg_in,
    input  wire logic [4:0]  write_reg_in,
    mem_access_unit_if.master mem,
    output logic             stall,
    output logic             wb_valid,
    output logic [31:0]      readdata_out,
    output logic [31:0]      ULAout_out,
    output logic [4:0]       write_reg_out,
    output logic             regwrite_out,
    output logic             memtoreg_out,
    output logic             busy,
    output logic             err_access,
    output logic             err_timeout,
    output logic [31:0]      load_count,
    output logic [31:0]      store_count,
    output logic [31:0]      stall_count
);

    localparam int                  c_WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_err_access;
    logic                r_err_timeout;

    logic                w_is_mem;
    logic                w_illegal;
    logic                w_start;
    logic                w_set_err_access;
    logic                w_set_err_timeout;
    logic                w_regwrite;
    logic [31:0]         w_readdata;

    assign w_is_mem  = memread_in | memwrite_in;
    assign w_illegal = (memread_in & memwrite_in) | (w_is_mem & (aluout_in[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are forced quiet while reset is held so the pipe never sees a
    // stall or writeback from a half-reset stage.
    always_comb begin
        w_state_nxt       = r_state;
        stall             = 1'b0;
        wb_valid          = 1'b0;
        w_regwrite        = 1'b0;
        w_readdata        = 32'h0;
        w_start           = 1'b0;
        w_set_err_access  = 1'b0;
        w_set_err_timeout = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!w_is_mem) begin
                            wb_valid   = 1'b1;
                            w_regwrite = regwrite_in;
                        end else if (w_illegal) begin
                            wb_valid         = 1'b1;
                            w_set_err_access = 1'b1;
                        end else begin
                            stall       = 1'b1;
                            w_start     = 1'b1;
                            w_state_nxt = S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem.mem_ack) begin
                        wb_valid    = 1'b1;
                        w_regwrite  = regwrite_in;
                        w_readdata  = r_mem_we ? 32'h0 : mem.mem_rdata;
                        w_state_nxt = S_IDLE;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        wb_valid          = 1'b1;
                        w_set_err_timeout = 1'b1;
                        w_state_nxt       = S_IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 32'h0;
            r_mem_wdata   <= 32'h0;
            r_err_access  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_start) begin
                r_wait_cnt  <= '0;
                r_mem_we    <= memwrite_in;
                r_mem_addr  <= aluout_in;
                r_mem_wdata <= writedata_in;
            end else if (r_state == S_ACCESS && stall) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
            end
            if (w_set_err_access) begin
                r_err_access <= 1'b1;
            end
            if (w_set_err_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign mem.mem_req   = (r_state == S_ACCESS);
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;

    assign busy          = (r_state == S_ACCESS);
    assign err_access    = r_err_access;
    assign err_timeout   = r_err_timeout;
    assign regwrite_out  = w_regwrite;
    assign readdata_out  = w_readdata;
    assign ULAout_out    = aluout_in;
    assign write_reg_out = write_reg_in;
    assign memtoreg_out  = memtoreg_in;

`ifdef MEM_STATS_EN
    logic        w_ack_load;
    logic        w_ack_store;
    logic [31:0] r_load_cnt;
    logic [31:0] r_store_cnt;
    logic [31:0] r_stall_cnt;

    assign w_ack_load  = (r_state == S_ACCESS) & mem.mem_ack & ~r_mem_we;
    assign w_ack_store = (r_state == S_ACCESS) & mem.mem_ack &  r_mem_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_cnt  <= 32'h0;
            r_store_cnt <= 32'h0;
            r_stall_cnt <= 32'h0;
        end else begin
            if (w_ack_load)  r_load_cnt  <= r_load_cnt + 32'd1;
            if (w_ack_store) r_store_cnt <= r_store_cnt + 32'd1;
            if (stall)       r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign load_count  = r_load_cnt;
    assign store_count = r_store_cnt;
    assign stall_count = r_stall_cnt;
`else
    assign load_count  = 32'h0;
    assign store_count = 32'h0;
    assign stall_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Scoreboard bench for mem_access_unit (ALU pass-through, load,
//            store, illegal access, timeout, back-to-back, reset mid-access).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

`ifdef MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [31:0] aluout_in;
    logic [31:0] writedata_in;
    logic        memread_in;
    logic        memwrite_in;
    logic        regwrite_in;
    logic        memtoreg_in;
    logic [4:0]  write_reg_in;
    logic        stall;
    logic        wb_valid;
    logic [31:0] readdata_out;
    logic [31:0] ULAout_out;
    logic [4:0]  write_reg_out;
    logic        regwrite_out;
    logic        memtoreg_out;
    logic        busy;
    logic        err_access;
    logic        err_timeout;
    logic [31:0] load_count;
    logic [31:0] store_count;
    logic [31:0] stall_count;

    mem_access_unit_if mem_if ();

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid),
        .aluout_in(aluout_in), .writedata_in(writedata_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in),
        .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
        .write_reg_in(write_reg_in), .mem(mem_if),
        .stall(stall), .wb_valid(wb_valid), .readdata_out(readdata_out),
        .ULAout_out(ULAout_out), .write_reg_out(write_reg_out),
        .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out),
        .busy(busy), .err_access(err_access), .err_timeout(err_timeout),
        .load_count(load_count), .store_count(store_count), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        regwrite;
        logic [31:0] readdata;
        logic [31:0] ula;
        logic [4:0]  wreg;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      errors = 0;
    int      checks = 0;
    int      exp_loads = 0;
    int      exp_stores = 0;
    int      exp_stalls = 0;

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rw, input logic [4:0] wreg);
        ex_valid     = v;
        memread_in   = rd;
        memwrite_in  = wr;
        aluout_in    = addr;
        writedata_in = wdata;
        regwrite_in  = rw;
        write_reg_in = wreg;
        memtoreg_in  = rd;
    endtask

    task automatic push_exp(input logic rw, input logic [31:0] rdata, input logic [31:0] ula, input logic [4:0] wreg);
        wb_exp_t e;
        e.regwrite = rw; e.readdata = rdata; e.ula = ula; e.wreg = wreg;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, wb_valid, regwrite_out, busy, mem_if.mem_req, mem_if.mem_we} !== 6'b0 ||
            mem_if.mem_addr !== 32'h0 || mem_if.mem_wdata !== 32'h0 || err_access !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b wb=%b rw=%b busy=%b req=%b we=%b addr=%h wdata=%h ea=%b et=%b, required all zero",
                     stall, wb_valid, regwrite_out, busy, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, err_access, err_timeout);
        end
        checks++;
        if ({load_count, store_count, stall_count} !== 96'h0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0d, required 0/0/0", load_count, store_count, stall_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_alu_op;
        wb_exp_t e;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 1'b1, 5'd5);
        push_exp(1'b1, 32'h0, 32'h1234, 5'd5);
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || stall !== 1'b0 || mem_if.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL alu_handshake: wb=%b stall=%b req=%b, required 1/0/0", wb_valid, stall, mem_if.mem_req);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL alu_sb: scoreboard empty, required one entry");
        end else begin
            e = sb.pop_front();
            if ({regwrite_out, readdata_out, ULAout_out, write_reg_out} !== {e.regwrite, e.readdata, e.ula, e.wreg}) begin
                errors++;
                $display("FAIL alu_wb: got rw=%b rd=%h ula=%h wr=%0d, required rw=%b rd=%h ula=%h wr=%0d",
                         regwrite_out, readdata_out, ULAout_out, write_reg_out, e.regwrite, e.readdata, e.ula, e.wreg);
            end
        end
        // Bubble with a stray ack: must produce nothing.
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h99, 32'h0, 1'b1, 5'd3);
        mem_if.mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || regwrite_out !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_bubble: wb=%b rw=%b busy=%b stall=%b, required all 0", wb_valid, regwrite_out, busy, stall);
        end
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
    endtask

    task automatic test_load;
        wb_exp_t e;
        int      stalls_seen = 0;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 5'd7);
        push_exp(1'b1, 32'hDEADBEEF, 32'h40, 5'd7);
        exp_loads++; exp_stalls += 4;
        @(negedge clk);
        if (stall) stalls_seen++;
        checks++;
        if (wb_valid !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL load_issue: wb=%b stall=%b, required 0/1", wb_valid, stall);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stall) stalls_seen++;
            checks++;
            if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b0 || mem_if.mem_addr !== 32'h40 ||
                busy !== 1'b1 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL load_access%0d: req=%b we=%b addr=%h busy=%b wb=%b, required 1/0/00000040/1/0",
                         i, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, busy, wb_valid);
            end
        end
        @(posedge clk); #1;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        if (stall) stalls_seen++;
        checks++;
        if (wb_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL load_ack_wb: wb=%b sb=%0d, required wb=1 with pending entry", wb_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if ({regwrite_out, readdata_out, ULAout_out, write_reg_out} !== {e.regwrite, e.readdata, e.ula, e.wreg}) begin
                errors++;
                $display("FAIL load_wb: got rw=%b rd=%h ula=%h wr=%0d, required rw=%b rd=%h ula=%h wr=%0d",
                         regwrite_out, readdata_out, ULAout_out, write_reg_out, e.regwrite, e.readdata, e.ula, e.wreg);
            end
        end
        checks++;
        if (stalls_seen != 4) begin
            errors++;
            $display("FAIL load_stall_cycles: got %0d, required 4", stalls_seen);
        end
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (mem_if.mem_req !== 1'b0 || busy !== 1'b0 || readdata_out !== 32'h0 ||
            load_count !== (STATS ? 32'(exp_loads) : 32'h0) || stall_count !== (STATS ? 32'(exp_stalls) : 32'h0)) begin
            errors++;
            $display("FAIL load_after: req=%b busy=%b rd=%h loads=%0d stalls=%0d, required 0/0/0/%0d/%0d",
                     mem_if.mem_req, busy, readdata_out, load_count, stall_count,
                     STATS ? exp_loads : 0, STATS ? exp_stalls : 0);
        end
    endtask

    task automatic test_store;
        wb_exp_t e;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 32'h44, 32'hCAFE0001, 1'b0, 5'd0);
        push_exp(1'b0, 32'h0, 32'h44, 5'd0);
        exp_stores++; exp_stalls += 1;
        @(posedge clk); #1;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'h55555555;
        @(negedge clk);
        checks++;
        if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b1 || mem_if.mem_addr !== 32'h44 ||
            mem_if.mem_wdata !== 32'hCAFE0001 || stall !== 1'b0 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL store_bus: req=%b we=%b addr=%h wdata=%h stall=%b wb=%b, required 1/1/00000044/cafe0001/0/1",
                     mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, stall, wb_valid);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL store_sb: scoreboard empty, required one entry");
        end else begin
            e = sb.pop_front();
            if ({regwrite_out, readdata_out, ULAout_out, write_reg_out} !== {e.regwrite, e.readdata, e.ula, e.wreg}) begin
                errors++;
                $display("FAIL store_wb: got rw=%b rd=%h ula=%h wr=%0d, required rw=%b rd=%h ula=%h wr=%0d",
                         regwrite_out, readdata_out, ULAout_out, write_reg_out, e.regwrite, e.readdata, e.ula, e.wreg);
            end
        end
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (store_count !== (STATS ? 32'(exp_stores) : 32'h0) || load_count !== (STATS ? 32'(exp_loads) : 32'h0) ||
            stall_count !== (STATS ? 32'(exp_stalls) : 32'h0) || mem_if.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL store_after: stores=%0d loads=%0d stalls=%0d req=%b, required %0d/%0d/%0d/0",
                     store_count, load_count, stall_count, mem_if.mem_req,
                     STATS ? exp_stores : 0, STATS ? exp_loads : 0, STATS ? exp_stalls : 0);
        end
    endtask

    task automatic test_illegal;
        wb_exp_t e;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (k == 0) drive(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 1'b1, 5'd9);
            else        drive(1'b1, 1'b1, 1'b1, 32'h50, 32'h0, 1'b1, 5'd10);
            push_exp(1'b0, 32'h0, aluout_in, write_reg_in);
            @(negedge clk);
            checks++;
            if (sb.size() == 0 || mem_if.mem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b1) begin
                errors++;
                $display("FAIL illegal%0d_handshake: req=%b stall=%b wb=%b sb=%0d, required 0/0/1 with entry",
                         k, mem_if.mem_req, stall, wb_valid, sb.size());
            end else begin
                e = sb.pop_front();
                if ({regwrite_out, readdata_out, ULAout_out, write_reg_out} !== {e.regwrite, e.readdata, e.ula, e.wreg}) begin
                    errors++;
                    $display("FAIL illegal%0d_wb: got rw=%b rd=%h ula=%h wr=%0d, required rw=%b rd=%h ula=%h wr=%0d",
                             k, regwrite_out, readdata_out, ULAout_out, write_reg_out, e.regwrite, e.readdata, e.ula, e.wreg);
                end
            end
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (err_access !== 1'b1 || err_timeout !== 1'b0 || busy !== 1'b0 ||
            load_count !== (STATS ? 32'(exp_loads) : 32'h0) || stall_count !== (STATS ? 32'(exp_stalls) : 32'h0)) begin
            errors++;
            $display("FAIL illegal_after: ea=%b et=%b busy=%b loads=%0d stalls=%0d, required 1/0/0/%0d/%0d",
                     err_access, err_timeout, busy, load_count, stall_count,
                     STATS ? exp_loads : 0, STATS ? exp_stalls : 0);
        end
    endtask

    task automatic test_timeout;
        wb_exp_t e;
        int      access_cycles = 0;
        bit      got = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 5'd12);
        push_exp(1'b0, 32'h0, 32'h80, 5'd12);
        exp_stalls += 16;
        @(negedge clk);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (busy) access_cycles++;
            if (wb_valid) begin
                got = 1'b1;
                checks++;
                if (sb.size() == 0 || stall !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_handshake: stall=%b sb=%0d, required 0 with entry", stall, sb.size());
                end else begin
                    e = sb.pop_front();
                    if ({regwrite_out, readdata_out, ULAout_out, write_reg_out} !== {e.regwrite, e.readdata, e.ula, e.wreg}) begin
                        errors++;
                        $display("FAIL timeout_wb: got rw=%b rd=%h ula=%h wr=%0d, required rw=%b rd=%h ula=%h wr=%0d",
                                 regwrite_out, readdata_out, ULAout_out, write_reg_out, e.regwrite, e.readdata, e.ula, e.wreg);
                    end
                end
            end
        end
        checks++;
        if (!got || access_cycles != 16) begin
            errors++;
            $display("FAIL timeout_cycles: wb seen=%b access cycles=%0d, required 1 and 16", got, access_cycles);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || mem_if.mem_req !== 1'b0 ||
            stall_count !== (STATS ? 32'(exp_stalls) : 32'h0) || load_count !== (STATS ? 32'(exp_loads) : 32'h0)) begin
            errors++;
            $display("FAIL timeout_after: et=%b busy=%b req=%b stalls=%0d loads=%0d, required 1/0/0/%0d/%0d",
                     err_timeout, busy, mem_if.mem_req, stall_count, load_count,
                     STATS ? exp_stalls : 0, STATS ? exp_loads : 0);
        end
    endtask

    task automatic test_back_to_back;
        wb_exp_t e;
        int      wb_seen = 0;
        // Two ALU ops then a minimum-latency load, on consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            case (k)
                0: begin drive(1'b1, 1'b0, 1'b0, 32'hA0A0, 32'h0, 1'b1, 5'd1); push_exp(1'b1, 32'h0, 32'hA0A0, 5'd1); end
                1: begin drive(1'b1, 1'b0, 1'b0, 32'hB0B0, 32'h0, 1'b0, 5'd2); push_exp(1'b0, 32'h0, 32'hB0B0, 5'd2); end
                2: begin drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 5'd3); push_exp(1'b1, 32'h0BADF00D, 32'h100, 5'd3);
                         exp_loads++; exp_stalls += 1; end
                default: begin mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h0BADF00D; end
            endcase
            @(negedge clk);
            if (wb_valid) begin
                wb_seen++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_sb%0d: wb_valid with empty scoreboard", k);
                end else begin
                    e = sb.pop_front();
                    if ({regwrite_out, readdata_out, ULAout_out, write_reg_out} !== {e.regwrite, e.readdata, e.ula, e.wreg}) begin
                        errors++;
                        $display("FAIL b2b_wb%0d: got rw=%b rd=%h ula=%h wr=%0d, required rw=%b rd=%h ula=%h wr=%0d",
                                 k, regwrite_out, readdata_out, ULAout_out, write_reg_out, e.regwrite, e.readdata, e.ula, e.wreg);
                    end
                end
            end
        end
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (wb_seen != 3 || sb.size() != 0 || load_count !== (STATS ? 32'(exp_loads) : 32'h0) ||
            stall_count !== (STATS ? 32'(exp_stalls) : 32'h0)) begin
            errors++;
            $display("FAIL b2b_summary: wb=%0d pending=%0d loads=%0d stalls=%0d, required 3/0/%0d/%0d",
                     wb_seen, sb.size(), load_count, stall_count, STATS ? exp_loads : 0, STATS ? exp_stalls : 0);
        end
    endtask

    task automatic test_reset_mid_access;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 5'd4);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || mem_if.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: busy=%b req=%b, required 1/1", busy, mem_if.mem_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_if.mem_req !== 1'b0 || stall !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0 ||
            err_access !== 1'b0 || err_timeout !== 1'b0 || {load_count, store_count, stall_count} !== 96'h0) begin
            errors++;
            $display("FAIL rst_mid_now: req=%b stall=%b busy=%b wb=%b ea=%b et=%b cnt=%0d/%0d/%0d, required all 0",
                     mem_if.mem_req, stall, busy, wb_valid, err_access, err_timeout, load_count, store_count, stall_count);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        reset = 1'b0;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || busy !== 1'b0 || mem_if.mem_req !== 1'b0 || readdata_out !== 32'h0 ||
            {load_count, store_count, stall_count} !== 96'h0) begin
            errors++;
            $display("FAIL rst_late_ack: wb=%b busy=%b req=%b rd=%h cnt=%0d/%0d/%0d, required all 0",
                     wb_valid, busy, mem_if.mem_req, readdata_out, load_count, store_count, stall_count);
        end
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
